// File: rtl/apb_tcdm_pkg.sv
// rtl/apb_tcdm_pkg.sv - shared types and constants for the APB-to-TCDM bridge
//
// Contents:
//   state_e      bridge FSM states
//   req_reg_t    APB transfer captured during the setup phase
//   TCDM_BE_FULL byte enables for full 32-bit TCDM accesses

package apb_tcdm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT_R = 3'd2,
    DONE   = 3'd3,
    DRAIN  = 3'd4
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
  } req_reg_t;

  localparam logic [3:0] TCDM_BE_FULL = 4'hF;

endpackage

// File: rtl/apb_to_tcdm_bridge.sv
// rtl/apb_to_tcdm_bridge.sv - APB responder forwarding each transfer as one 32-bit TCDM request
//
// Optional build macro: APB_TCDM_TIMEOUT_EN (request/response timeout plus DRAIN state).
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   paddr_i, pwdata_i, pwrite_i   APB address, write data, direction (1 = write)
//   psel_i, penable_i             APB select and access phase
//   prdata_o, pready_o, pslverr_o APB read data, transfer complete, error
//   tcdm_req_o, tcdm_add_o        TCDM request and word-aligned byte address
//   tcdm_wen_o, tcdm_wdata_o      TCDM write enable (0 = write) and write data
//   tcdm_be_o                     TCDM byte enables (always full word)
//   tcdm_gnt_i                    TCDM grant
//   tcdm_r_valid_i, tcdm_r_rdata_i, tcdm_r_opc_i  TCDM response valid, data, error

module apb_to_tcdm_bridge
  import apb_tcdm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h1C00_0000,
  parameter logic [31:0] WIN_SIZE       = 32'h0008_0000,
  parameter logic [31:0] ADDR_OFFSET    = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] paddr_i,
  input  logic [31:0] pwdata_i,
  input  logic        pwrite_i,
  input  logic        psel_i,
  input  logic        penable_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic        tcdm_req_o,
  output logic [31:0] tcdm_add_o,
  output logic        tcdm_wen_o,
  output logic [31:0] tcdm_wdata_o,
  output logic [3:0]  tcdm_be_o,
  input  logic        tcdm_gnt_i,
  input  logic        tcdm_r_valid_i,
  input  logic [31:0] tcdm_r_rdata_i,
  input  logic        tcdm_r_opc_i
);

  if (WIN_SIZE < 32'd4 || (WIN_SIZE & (WIN_SIZE - 32'd1)) != 32'd0 || TIMEOUT_CYCLES < 2)
  begin : g_bad_param
    $error("apb_to_tcdm_bridge: WIN_SIZE must be a power of two >= 4, TIMEOUT_CYCLES >= 2");
  end

  state_e      state_q;
  req_reg_t    req_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        hold_q;   // out-of-window error waits one extra cycle in DONE
  logic        abort_q;  // psel dropped mid-transfer: discard the result
  logic        aborted;
  logic        timeout;
  logic        drain_q;

  // Unsigned offset from the window base; addresses below BASE_ADDR wrap to
  // large values, so one compare covers both window edges.
  function automatic logic in_window(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return off < WIN_SIZE;
  endfunction

  assign aborted = abort_q | ~psel_i;

`ifdef APB_TCDM_TIMEOUT_EN
  localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  assign timeout = (cnt_q == CNT_LAST);

  // REQ is only entered from IDLE, so clearing in IDLE is the same as
  // clearing on entry to REQ. Counting continues from REQ into WAIT_R.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        cnt_q <= '0;
      end else if ((state_q == REQ || state_q == WAIT_R) && !timeout) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (state_q == WAIT_R && !tcdm_r_valid_i && timeout) begin
        drain_q <= 1'b1;
      end else if (state_q == DRAIN || state_q == IDLE) begin
        drain_q <= 1'b0;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign drain_q = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (psel_i && !penable_i) begin
            req_q.addr  <= paddr_i;
            req_q.wdata <= pwdata_i;
            req_q.write <= pwrite_i;
            rdata_q     <= '0;
            abort_q     <= 1'b0;
            if (in_window(paddr_i)) begin
              state_q <= REQ;
              err_q   <= 1'b0;
              hold_q  <= 1'b0;
            end else begin
              state_q <= DONE;
              err_q   <= 1'b1;
              hold_q  <= 1'b1;
            end
          end
        end

        REQ: begin
          if (!psel_i) abort_q <= 1'b1;
          if (tcdm_gnt_i && tcdm_r_valid_i) begin
            // zero-latency responder: grant and response in the same cycle
            err_q <= tcdm_r_opc_i;
            if (!req_q.write && !tcdm_r_opc_i) rdata_q <= tcdm_r_rdata_i;
            state_q <= aborted ? IDLE : DONE;
          end else if (tcdm_gnt_i) begin
            state_q <= WAIT_R;
          end else if (timeout) begin
            // never granted, so no response can follow: no drain needed
            err_q   <= 1'b1;
            state_q <= aborted ? IDLE : DONE;
          end
        end

        WAIT_R: begin
          if (!psel_i) abort_q <= 1'b1;
          if (tcdm_r_valid_i) begin
            err_q <= tcdm_r_opc_i;
            if (!req_q.write && !tcdm_r_opc_i) rdata_q <= tcdm_r_rdata_i;
            state_q <= aborted ? IDLE : DONE;
          end else if (timeout) begin
            err_q   <= 1'b1;
            state_q <= aborted ? DRAIN : DONE;
          end
        end

        DONE: begin
          if (hold_q) begin
            hold_q <= 1'b0;
            if (!psel_i) state_q <= IDLE;
          end else begin
            state_q <= drain_q ? DRAIN : IDLE;
          end
        end

        DRAIN: begin
          // the late response of a timed-out read/write is swallowed here
          if (tcdm_r_valid_i) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign pready_o  = (state_q == DONE) && !hold_q;
  assign prdata_o  = pready_o ? rdata_q : '0;
  assign pslverr_o = pready_o & err_q;

  // Request-side outputs are only driven while requesting, which also keeps
  // them at their reset values in every other state.
  assign tcdm_req_o   = (state_q == REQ);
  assign tcdm_add_o   = tcdm_req_o ? ((req_q.addr + ADDR_OFFSET) & 32'hFFFF_FFFC) : '0;
  assign tcdm_wen_o   = tcdm_req_o ? ~req_q.write : 1'b1;
  assign tcdm_wdata_o = tcdm_req_o ? req_q.wdata : '0;
  assign tcdm_be_o    = TCDM_BE_FULL;

endmodule
